// File: rtl/vector_seq_pkg.sv
// Shared types and width helpers for the vector sequencer.
package vector_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LAUNCH = 3'd2,
      RUN    = 3'd3,
      DRAIN  = 3'd4,
      FINISH = 3'd5
   } seq_state_e;

   // Index widths never collapse to zero bits, even for a single-entry range.
   function automatic int lane_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int flag_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int vec_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_flag_reg.sv
// Shared flag register written by several lanes at once. When set and clear
// land on the same bit in one cycle, the set wins. An index outside the
// register decodes to no bit and is therefore dropped.
module seq_flag_reg
   import vector_seq_pkg::*;
#(
   parameter int NLANE      = 4,
   parameter int FLAG_COUNT = 8,
   localparam int FIW       = flag_idx_w(FLAG_COUNT)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [NLANE-1:0]      flag_set,
   input  logic [NLANE-1:0]      flag_clr,
   input  logic [NLANE*FIW-1:0]  flag_idx,
   output logic [FLAG_COUNT-1:0] flags
);

   logic [NLANE-1:0][FLAG_COUNT-1:0] set_dec;
   logic [NLANE-1:0][FLAG_COUNT-1:0] clr_dec;
   logic [FLAG_COUNT-1:0]            set_any;
   logic [FLAG_COUNT-1:0]            clr_any;
   logic [FLAG_COUNT-1:0]            flags_q;
   logic [FLAG_COUNT-1:0]            flags_d;

   // One-hot decode of each lane's request; only in-range indices can match.
   for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      for (genvar gb = 0; gb < FLAG_COUNT; gb++) begin : g_bit
         assign set_dec[gi][gb] = flag_set[gi] && (flag_idx[gi*FIW +: FIW] == FIW'(gb));
         assign clr_dec[gi][gb] = flag_clr[gi] && (flag_idx[gi*FIW +: FIW] == FIW'(gb));
      end
   end

   // Merge all lanes, apply clears first so a coincident set survives.
   always_comb begin
      set_any = '0;
      clr_any = '0;
      for (int i = 0; i < NLANE; i++) begin
         set_any = set_any | set_dec[i];
         clr_any = clr_any | clr_dec[i];
      end
      flags_d = flags_q;
      if (clear) begin
         flags_d = '0;
      end else if (enable) begin
         flags_d = (flags_q & ~clr_any) | set_any;
      end
   end

   // Flag storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;

endmodule

// File: rtl/vector_sequencer.sv
// Sequences test vectors across parallel stimulus lanes: fetch a descriptor
// list, launch non-empty sections, wait for the first lane to finish, abort
// the rest, then move on. Tracks lane errors and descriptor-format errors.
module vector_sequencer
   import vector_seq_pkg::*;
#(
   parameter int MAX_PARALLEL = 4,
   parameter int MAX_VECTORS  = 16,
   parameter int FLAG_COUNT   = 8,
   parameter int SEEK_W       = 64,
   localparam int LIW         = lane_idx_w(MAX_PARALLEL),
   localparam int FIW         = flag_idx_w(FLAG_COUNT),
   localparam int VIW         = vec_idx_w(MAX_VECTORS),
   localparam int VCW         = $clog2(MAX_VECTORS + 1),
   localparam int DCW         = $clog2(MAX_PARALLEL + 1)
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [VCW-1:0]               vector_count,
   input  logic                         desc_valid,
   output logic                         desc_ready,
   input  logic [DCW-1:0]               desc_count,
   input  logic [SEEK_W-1:0]            desc_offset,
   input  logic                         desc_last,
   output logic [MAX_PARALLEL-1:0]      lane_start,
   output logic [MAX_PARALLEL*SEEK_W-1:0] lane_offset,
   output logic [MAX_PARALLEL-1:0]      lane_abort,
   input  logic [MAX_PARALLEL-1:0]      lane_done,
   input  logic [MAX_PARALLEL-1:0]      lane_error,
   input  logic [MAX_PARALLEL-1:0]      flag_set,
   input  logic [MAX_PARALLEL-1:0]      flag_clr,
   input  logic [MAX_PARALLEL*FIW-1:0]  flag_idx,
   output logic [FLAG_COUNT-1:0]        flags,
   output logic [VIW-1:0]               vector_idx,
   output logic                         busy,
   output logic                         run_done,
   output logic                         pass,
   output logic                         fmt_error
);

   localparam logic [DCW-1:0] MAXP = DCW'(MAX_PARALLEL);

   seq_state_e                              state_q, state_d;
   logic [VCW-1:0]                          vcount_q, vcount_d;
   logic [VIW-1:0]                          vidx_q, vidx_d;
   logic [LIW-1:0]                          beat_q, beat_d;
   logic [DCW-1:0]                          dcount_q, dcount_d;
   logic [MAX_PARALLEL-1:0][SEEK_W-1:0]     offset_q, offset_d;
   logic [MAX_PARALLEL-1:0]                 active_q, active_d;
   logic [MAX_PARALLEL-1:0]                 done_q, done_d;
   logic                                    err_q, err_d;
   logic                                    fmt_q, fmt_d;
   logic                                    pass_q, pass_d;

   logic [MAX_PARALLEL-1:0]                 nz_mask;
   logic [MAX_PARALLEL-1:0]                 act_mask;
   logic [MAX_PARALLEL-1:0]                 hit;
   logic [DCW-1:0]                          eff_count;
   logic [DCW-1:0]                          beat_num;
   logic                                    flag_clear;

   // A lane is launchable when its section offset is non-zero.
   for (genvar gi = 0; gi < MAX_PARALLEL; gi++) begin : g_nz
      assign nz_mask[gi] = |offset_q[gi];
   end

   // Next-state logic and Moore outputs.
   always_comb begin
      state_d    = state_q;
      vcount_d   = vcount_q;
      vidx_d     = vidx_q;
      beat_d     = beat_q;
      dcount_d   = dcount_q;
      offset_d   = offset_q;
      active_d   = active_q;
      done_d     = done_q;
      err_d      = err_q;
      fmt_d      = fmt_q;
      pass_d     = pass_q;
      desc_ready = 1'b0;
      lane_start = '0;
      lane_abort = '0;
      run_done   = 1'b0;
      flag_clear = 1'b0;
      hit        = lane_done & active_q;
      // Section count arrives on the first beat only; later beats use the copy.
      eff_count  = (beat_q == '0) ? desc_count : dcount_q;
      beat_num   = DCW'(beat_q) + DCW'(1);
      // During LAUNCH the lanes about to start already count as active.
      act_mask   = (state_q == LAUNCH) ? nz_mask : active_q;

      if (state_q == LAUNCH || state_q == RUN || state_q == DRAIN) begin
         err_d = err_q | (|(lane_error & act_mask));
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               vcount_d   = vector_count;
               vidx_d     = '0;
               beat_d     = '0;
               err_d      = 1'b0;
               fmt_d      = 1'b0;
               pass_d     = 1'b0;
               flag_clear = 1'b1;
               state_d    = (vector_count == '0) ? FINISH : FETCH;
            end
         end
         FETCH: begin
            desc_ready = 1'b1;
            if (desc_valid) begin
               if (beat_q == '0) begin
                  dcount_d = desc_count;
               end
               if (eff_count == '0 || eff_count > MAXP ||
                   desc_last != (beat_num == eff_count)) begin
                  fmt_d    = 1'b1;
                  offset_d = '0;
                  beat_d   = '0;
                  state_d  = FINISH;
               end else begin
                  offset_d[beat_q] = desc_offset;
                  if (desc_last) begin
                     beat_d  = '0;
                     state_d = LAUNCH;
                  end else begin
                     beat_d  = beat_q + LIW'(1);
                  end
               end
            end
         end
         LAUNCH: begin
            lane_start = nz_mask;
            active_d   = nz_mask;
            done_d     = '0;
            state_d    = (|nz_mask) ? RUN : DRAIN;
         end
         RUN: begin
            if (|hit) begin
               done_d  = hit;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            lane_abort = active_q & ~done_q;
            active_d   = '0;
            done_d     = '0;
            offset_d   = '0;
            if (VCW'(vidx_q) == vcount_q - VCW'(1)) begin
               state_d = FINISH;
            end else begin
               vidx_d  = vidx_q + VIW'(1);
               state_d = FETCH;
            end
         end
         FINISH: begin
            run_done = 1'b1;
            pass_d   = ~err_q & ~fmt_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset may land mid-run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         vcount_q <= '0;
         vidx_q   <= '0;
         beat_q   <= '0;
         dcount_q <= '0;
         offset_q <= '0;
         active_q <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
         fmt_q    <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vcount_q <= vcount_d;
         vidx_q   <= vidx_d;
         beat_q   <= beat_d;
         dcount_q <= dcount_d;
         offset_q <= offset_d;
         active_q <= active_d;
         done_q   <= done_d;
         err_q    <= err_d;
         fmt_q    <= fmt_d;
         pass_q   <= pass_d;
      end
   end

   seq_flag_reg #(
      .NLANE      (MAX_PARALLEL),
      .FLAG_COUNT (FLAG_COUNT)
   ) u_flags (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flag_clear),
      .enable   (state_q != IDLE),
      .flag_set (flag_set),
      .flag_clr (flag_clr),
      .flag_idx (flag_idx),
      .flags    (flags)
   );

   assign lane_offset = offset_q;
   assign vector_idx  = vidx_q;
   assign busy        = (state_q != IDLE);
   assign fmt_error   = fmt_q;
   // The verdict is visible in the same cycle as run_done, then held.
   assign pass        = (state_q == FINISH) ? (~err_q & ~fmt_q) : pass_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer. Six flags are used so that a 3-bit
// flag index can actually name an out-of-range bit (6 and 7).
module tb_vector_sequencer;

   localparam int NP  = 4;
   localparam int FC  = 6;
   localparam int SW  = 64;
   localparam int FIW = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [4:0]        vector_count = '0;
   logic              desc_valid = 1'b0;
   logic              desc_ready;
   logic [2:0]        desc_count = '0;
   logic [SW-1:0]     desc_offset = '0;
   logic              desc_last = 1'b0;
   logic [NP-1:0]     lane_start;
   logic [NP*SW-1:0]  lane_offset;
   logic [NP-1:0]     lane_abort;
   logic [NP-1:0]     lane_done = '0;
   logic [NP-1:0]     lane_error = '0;
   logic [NP-1:0]     flag_set = '0;
   logic [NP-1:0]     flag_clr = '0;
   logic [NP*FIW-1:0] flag_idx = '0;
   logic [FC-1:0]     flags;
   logic [3:0]        vector_idx;
   logic              busy;
   logic              run_done;
   logic              pass;
   logic              fmt_error;

   int n_checks = 0;
   int n_pass   = 0;

   vector_sequencer #(
      .MAX_PARALLEL (NP),
      .MAX_VECTORS  (16),
      .FLAG_COUNT   (FC),
      .SEEK_W       (SW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .vector_count (vector_count),
      .desc_valid   (desc_valid),
      .desc_ready   (desc_ready),
      .desc_count   (desc_count),
      .desc_offset  (desc_offset),
      .desc_last    (desc_last),
      .lane_start   (lane_start),
      .lane_offset  (lane_offset),
      .lane_abort   (lane_abort),
      .lane_done    (lane_done),
      .lane_error   (lane_error),
      .flag_set     (flag_set),
      .flag_clr     (flag_clr),
      .flag_idx     (flag_idx),
      .flags        (flags),
      .vector_idx   (vector_idx),
      .busy         (busy),
      .run_done     (run_done),
      .pass         (pass),
      .fmt_error    (fmt_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int vc);
      start        = 1'b1;
      vector_count = 5'(vc);
      tick();
      start        = 1'b0;
   endtask

   task automatic beat(input int cnt, input logic [63:0] off, input bit last);
      desc_valid  = 1'b1;
      desc_count  = 3'(cnt);
      desc_offset = off;
      desc_last   = last;
      tick();
      desc_valid  = 1'b0;
      desc_last   = 1'b0;
   endtask

   task automatic flag_req(input int lane, input bit s, input bit c, input int idx);
      flag_set[lane]              = s;
      flag_clr[lane]              = c;
      flag_idx[lane*FIW +: FIW]   = 3'(idx);
   endtask

   task automatic flag_idle();
      flag_set = '0;
      flag_clr = '0;
      flag_idx = '0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_desc_ready", 64'(desc_ready), 64'd0);
      check("rst_pass", 64'(pass), 64'd0);
      check("rst_run_done", 64'(run_done), 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic two-vector run
      do_start(2);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_desc_ready", 64'(desc_ready), 64'd1);
      beat(2, 64'h40, 1'b0);
      beat(2, 64'h80, 1'b1);
      check("t1_v0_start", 64'(lane_start), 64'b0011);
      check("t1_v0_off0", lane_offset[0 +: 64], 64'h40);
      check("t1_v0_off1", lane_offset[64 +: 64], 64'h80);
      tick();
      check("t1_start_clear", 64'(lane_start), 64'd0);
      lane_done = 4'b0010;
      tick();
      lane_done = '0;
      check("t1_v0_abort", 64'(lane_abort), 64'b0001);
      tick();
      check("t1_vidx", 64'(vector_idx), 64'd1);
      beat(1, 64'h100, 1'b1);
      check("t1_v1_start", 64'(lane_start), 64'b0001);
      check("t1_v1_off0", lane_offset[0 +: 64], 64'h100);
      tick();
      lane_done = 4'b0001;
      tick();
      lane_done = '0;
      check("t1_v1_abort", 64'(lane_abort), 64'd0);
      tick();
      check("t1_run_done", 64'(run_done), 64'd1);
      check("t1_pass", 64'(pass), 64'd1);
      tick();
      check("t1_idle_busy", 64'(busy), 64'd0);
      check("t1_idle_done", 64'(run_done), 64'd0);
      check("t1_pass_hold", 64'(pass), 64'd1);

      // Empty sections, then an all-empty vector
      do_start(2);
      beat(3, 64'h10, 1'b0);
      beat(3, 64'h0, 1'b0);
      beat(3, 64'h30, 1'b1);
      check("t2_start", 64'(lane_start), 64'b0101);
      check("t2_off1", lane_offset[64 +: 64], 64'h0);
      check("t2_off2", lane_offset[128 +: 64], 64'h30);
      tick();
      lane_done = 4'b0100;
      tick();
      lane_done = '0;
      check("t2_abort", 64'(lane_abort), 64'b0001);
      tick();
      beat(2, 64'h0, 1'b0);
      beat(2, 64'h0, 1'b1);
      check("t2_empty_start", 64'(lane_start), 64'd0);
      tick();
      check("t2_empty_abort", 64'(lane_abort), 64'd0);
      tick();
      check("t2_run_done", 64'(run_done), 64'd1);
      check("t2_pass", 64'(pass), 64'd1);
      tick();

      // Inactive-lane error and done are ignored
      do_start(1);
      beat(1, 64'h20, 1'b1);
      tick();
      lane_error = 4'b1000;
      lane_done  = 4'b0100;
      tick();
      lane_error = '0;
      lane_done  = '0;
      check("t3_ignore_done", 64'(lane_abort), 64'd0);
      check("t3_still_busy", 64'(busy), 64'd1);
      lane_done = 4'b0001;
      tick();
      lane_done = '0;
      tick();
      check("t3_run_done", 64'(run_done), 64'd1);
      check("t3_inactive_err_pass", 64'(pass), 64'd1);
      tick();

      // Error coincident with done on the final vector
      do_start(1);
      beat(1, 64'h20, 1'b1);
      tick();
      lane_error = 4'b0001;
      lane_done  = 4'b0001;
      tick();
      lane_error = '0;
      lane_done  = '0;
      tick();
      check("t3_err_run_done", 64'(run_done), 64'd1);
      check("t3_err_pass", 64'(pass), 64'd0);
      tick();
      check("t3_err_pass_hold", 64'(pass), 64'd0);

      // Format errors: zero count, oversize count, early and late last
      do_start(1);
      beat(0, 64'h10, 1'b1);
      check("t4_c0_done", 64'(run_done), 64'd1);
      check("t4_c0_fmt", 64'(fmt_error), 64'd1);
      check("t4_c0_pass", 64'(pass), 64'd0);
      check("t4_c0_start", 64'(lane_start), 64'd0);
      tick();
      check("t4_fmt_sticky", 64'(fmt_error), 64'd1);
      do_start(1);
      check("t4_fmt_cleared", 64'(fmt_error), 64'd0);
      beat(5, 64'h10, 1'b1);
      check("t4_c5_done", 64'(run_done), 64'd1);
      check("t4_c5_fmt", 64'(fmt_error), 64'd1);
      check("t4_c5_pass", 64'(pass), 64'd0);
      tick();
      do_start(1);
      beat(2, 64'h10, 1'b1);
      check("t4_early_fmt", 64'(fmt_error), 64'd1);
      check("t4_early_done", 64'(run_done), 64'd1);
      tick();
      do_start(1);
      beat(1, 64'h10, 1'b0);
      check("t4_late_fmt", 64'(fmt_error), 64'd1);
      check("t4_late_start", 64'(lane_start), 64'd0);
      tick();

      // Flags: set beats clear, out-of-range ignored, idle ignored
      do_start(1);
      check("t5_flags_cleared", 64'(flags), 64'd0);
      beat(1, 64'h8, 1'b1);
      tick();
      flag_req(0, 1'b1, 1'b0, 3);
      flag_req(1, 1'b0, 1'b1, 3);
      tick();
      flag_idle();
      check("t5_set_wins", 64'(flags), 64'b001000);
      flag_req(2, 1'b1, 1'b0, 7);
      flag_req(3, 1'b1, 1'b0, 6);
      tick();
      flag_idle();
      check("t5_out_of_range", 64'(flags), 64'b001000);
      flag_req(0, 1'b1, 1'b0, 0);
      flag_req(1, 1'b0, 1'b1, 3);
      tick();
      flag_idle();
      check("t5_multi_lane", 64'(flags), 64'b000001);
      lane_done = 4'b0001;
      tick();
      lane_done = '0;
      tick();
      check("t5_run_done", 64'(run_done), 64'd1);
      tick();
      flag_req(0, 1'b1, 1'b0, 5);
      tick();
      flag_idle();
      check("t5_idle_ignored", 64'(flags), 64'b000001);

      // Asynchronous reset mid-run
      do_start(1);
      flag_req(0, 1'b1, 1'b0, 2);
      beat(1, 64'h50, 1'b1);
      flag_idle();
      check("t6_flag_set", 64'(flags), 64'b000100);
      tick();
      rst_n = 1'b0;
      #1;
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_flags", 64'(flags), 64'd0);
      check("t6_offset", 64'(|lane_offset), 64'd0);
      check("t6_start", 64'(lane_start), 64'd0);
      check("t6_abort", 64'(lane_abort), 64'd0);
      check("t6_ready", 64'(desc_ready), 64'd0);
      check("t6_fmt", 64'(fmt_error), 64'd0);
      check("t6_pass", 64'(pass), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Zero-vector run
      do_start(0);
      check("t6_zero_done", 64'(run_done), 64'd1);
      check("t6_zero_pass", 64'(pass), 64'd1);
      tick();
      check("t6_zero_idle", 64'(run_done), 64'd0);
      check("t6_zero_busy", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
